// File: rtl/regfile_alu_seq.sv
// Register-file + ALU sequencer: phased instruction entry via active-low strobes, one ALU op per execute.
// Optional feature macro: REGFILE_CLR_ALL_EN (opcode F clears all registers and flags).
module regfile_alu_seq #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int SW_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   data_input,
  input  logic              ld_Reg,
  input  logic              ld_Setup,
  input  logic              ld_Imm,
  input  logic              ld_Inst,
  output logic [4:0]        Flags,
  output logic [DATA_W-1:0] RdestOut,
  output logic [2:0]        state,
  output logic              op_done
);

  localparam int RIDX_W = $clog2(NUM_REGS);
  localparam int MSB    = DATA_W - 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HAVE_REG = 3'd1,
    HAVE_OP  = 3'd2,
    ARMED    = 3'd3,
    EXEC     = 3'd4
  } state_t;

  state_t              st_q, st_d;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [RIDX_W-1:0]   rdest_q, rsrc_q;
  logic [3:0]          op_q;
  logic                imm_mode_q;
  logic [DATA_W-1:0]   imm_q;
  logic [4:0]          flags_q, flags_d;
  logic                reg_d, setup_d, imm_d, inst_d;
  logic                reg_ev, setup_ev, imm_ev, inst_ev;
  logic                cap_reg, cap_setup, cap_imm;
  logic [DATA_W-1:0]   a, b, res;
  logic [DATA_W:0]     sum, diff;
  logic                wr_en, clr_all;

  // Act only on the 1->0 transition of each strobe so a held button is one event.
  assign reg_ev   = reg_d   & ~ld_Reg;
  assign setup_ev = setup_d & ~ld_Setup;
  assign imm_ev   = imm_d   & ~ld_Imm;
  assign inst_ev  = inst_d  & ~ld_Inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_d   <= 1'b1;
      setup_d <= 1'b1;
      imm_d   <= 1'b1;
      inst_d  <= 1'b1;
    end else begin
      reg_d   <= ld_Reg;
      setup_d <= ld_Setup;
      imm_d   <= ld_Imm;
      inst_d  <= ld_Inst;
    end
  end

  // ld_Reg restarts the sequence from any state but EXEC and outranks other strobes.
  always_comb begin
    st_d      = st_q;
    cap_reg   = 1'b0;
    cap_setup = 1'b0;
    cap_imm   = 1'b0;
    if (reg_ev && st_q != EXEC) begin
      cap_reg = 1'b1;
      st_d    = HAVE_REG;
    end else begin
      case (st_q)
        HAVE_REG: begin
          if (setup_ev) begin
            cap_setup = 1'b1;
            st_d      = data_input[SW_W-5] ? HAVE_OP : ARMED;
          end
        end
        HAVE_OP: begin
          if (imm_ev) begin
            cap_imm = 1'b1;
            st_d    = ARMED;
          end
        end
        ARMED: begin
          if (inst_ev) st_d = EXEC;
        end
        EXEC:    st_d = IDLE;
        IDLE:    st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  assign a    = regs[rdest_q];
  assign b    = imm_mode_q ? imm_q : regs[rsrc_q];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // ALU result and flag update; flags are {C, L, F, Z, N}.
  always_comb begin
    res     = '0;
    wr_en   = 1'b0;
    clr_all = 1'b0;
    flags_d = flags_q;
    case (op_q)
      4'h0: begin
        res        = sum[MSB:0];
        wr_en      = 1'b1;
        flags_d[4] = sum[DATA_W];
        flags_d[2] = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
        flags_d[1] = (res == '0);
      end
      4'h1: begin
        res        = diff[MSB:0];
        wr_en      = 1'b1;
        flags_d[4] = diff[DATA_W];
        flags_d[2] = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
        flags_d[1] = (res == '0);
      end
      4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8: begin
        case (op_q)
          4'h2:    res = a & b;
          4'h3:    res = a | b;
          4'h4:    res = a ^ b;
          4'h5:    res = b;
          4'h7:    res = a << b[3:0];
          default: res = a >> b[3:0];
        endcase
        wr_en      = 1'b1;
        flags_d[1] = (res == '0);
      end
      4'h6: begin
        flags_d[3] = (a < b);
        flags_d[1] = (a == b);
        flags_d[0] = ($signed(a) < $signed(b));
      end
`ifdef REGFILE_CLR_ALL_EN
      4'hF: begin
        clr_all = 1'b1;
        flags_d = 5'b00000;
      end
`endif
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Phase state, captured operands, and the writeback edge that follows EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      rdest_q    <= '0;
      rsrc_q     <= '0;
      op_q       <= 4'h0;
      imm_mode_q <= 1'b0;
      imm_q      <= '0;
      flags_q    <= 5'b00000;
      op_done    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      st_q    <= st_d;
      op_done <= (st_q == EXEC);
      if (cap_reg) begin
        rdest_q <= data_input[SW_W-1 -: RIDX_W];
        rsrc_q  <= data_input[SW_W-1-RIDX_W -: RIDX_W];
      end
      if (cap_setup) begin
        op_q       <= data_input[SW_W-1 -: 4];
        imm_mode_q <= data_input[SW_W-5];
      end
      if (cap_imm) imm_q <= DATA_W'($signed(data_input));
      if (st_q == EXEC) begin
        flags_q <= flags_d;
        if (clr_all) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
          regs[rdest_q] <= res;
        end
      end
    end
  end

  assign Flags    = flags_q;
  assign RdestOut = regs[rdest_q];
  assign state    = st_q;

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Directed bench for regfile_alu_seq (default parameters); honours REGFILE_CLR_ALL_EN for CLR expectations.
module tb_regfile_alu_seq;
  logic        clk;
  logic        rst;
  logic [9:0]  data_input;
  logic        ld_Reg, ld_Setup, ld_Imm, ld_Inst;
  logic [4:0]  Flags;
  logic [15:0] RdestOut;
  logic [2:0]  state;
  logic        op_done;
  int          total;
  int          passed;
  int          pulses;

  regfile_alu_seq dut (
    .clk(clk), .rst(rst), .data_input(data_input),
    .ld_Reg(ld_Reg), .ld_Setup(ld_Setup), .ld_Imm(ld_Imm), .ld_Inst(ld_Inst),
    .Flags(Flags), .RdestOut(RdestOut), .state(state), .op_done(op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // m = {reg, setup, imm, inst}: strobes driven low for one clock
  task automatic pulse(input logic [3:0] m, input logic [9:0] d);
    @(negedge clk);
    data_input = d;
    {ld_Reg, ld_Setup, ld_Imm, ld_Inst} = ~m;
    @(negedge clk);
    {ld_Reg, ld_Setup, ld_Imm, ld_Inst} = 4'b1111;
  endtask

  task automatic exec(input string tag);
    pulse(4'b0001, 10'd0);
    chk({tag, "_exec_state"}, state, 3'd4);
    @(negedge clk);
    chk({tag, "_op_done"}, op_done, 1'b1);
    chk({tag, "_idle"}, state, 3'd0);
  endtask

  task automatic run_imm(input string tag, input logic [9:0] r, input logic [9:0] s, input logic [9:0] i);
    pulse(4'b1000, r);
    pulse(4'b0100, s);
    pulse(4'b0010, i);
    exec(tag);
  endtask

  task automatic run_reg(input string tag, input logic [9:0] r, input logic [9:0] s);
    pulse(4'b1000, r);
    pulse(4'b0100, s);
    exec(tag);
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; data_input = 10'd0;
    {ld_Reg, ld_Setup, ld_Imm, ld_Inst} = 4'b1111;
    #12 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_flags", Flags, 5'b00000);
    chk("rst_rdest", RdestOut, 16'h0000);
    chk("rst_op_done", op_done, 1'b0);

    // ADD immediate: R1 = 0 + 8
    run_imm("add", 10'b0001000000, 10'b0000100000, 10'b0000001000);
    chk("add_r1", RdestOut, 16'h0008);
    chk("add_flags", Flags, 5'b00000);
    @(negedge clk);
    chk("add_op_done_fall", op_done, 1'b0);

    // SUB immediate 9 from 8: borrow
    run_imm("sub", 10'b0001000000, 10'b0001100000, 10'b0000001001);
    chk("sub_r1", RdestOut, 16'hFFFF);
    chk("sub_flags", Flags, 5'b10000);

    // R2 = 0x1FF << 6, R3 = 0x40, then ADD R2,R3 overflows
    run_imm("mov_r2", 10'b0010000000, 10'b0101100000, 10'b0111111111);
    chk("mov_r2", RdestOut, 16'h01FF);
    run_imm("lsh_r2", 10'b0010000000, 10'b0111100000, 10'b0000000110);
    chk("lsh_r2", RdestOut, 16'h7FC0);
    chk("lsh_flags", Flags, 5'b10000);
    run_imm("mov_r3", 10'b0011000000, 10'b0101100000, 10'b0001000000);
    chk("mov_r3", RdestOut, 16'h0040);
    run_reg("addr", 10'b0010001100, 10'b0000000000);
    chk("addr_r2", RdestOut, 16'h8000);
    chk("addr_flags", Flags, 5'b00100);

    // CMP R2,R3: 0x8000 vs 0x0040
    run_reg("cmp", 10'b0010001100, 10'b0110000000);
    chk("cmp_r2", RdestOut, 16'h8000);
    chk("cmp_flags", Flags, 5'b00101);

    // Ordering and abort
    pulse(4'b0001, 10'd0);
    chk("inst_idle_state", state, 3'd0);
    @(negedge clk);
    chk("inst_idle_no_done", op_done, 1'b0);
    pulse(4'b1000, 10'b0011001000);
    chk("reg_state", state, 3'd1);
    chk("reg_rdest_follow", RdestOut, 16'h0040);
    pulse(4'b0010, 10'b0000000001);
    chk("imm_in_have_reg", state, 3'd1);
    pulse(4'b0100, 10'b0000000000);
    chk("armed", state, 3'd3);
    pulse(4'b1000, 10'b0010001100);
    chk("abort_armed", state, 3'd1);
    chk("abort_rdest", RdestOut, 16'h8000);
    pulse(4'b1100, 10'b0000100000);
    chk("reg_setup_same", state, 3'd1);

    // ld_Setup held low 5 cycles with an ld_Reg restart in the middle
    @(negedge clk);
    data_input = 10'b0010001100;
    ld_Setup = 1'b0;
    @(negedge clk);
    chk("held_setup_first", state, 3'd3);
    ld_Reg = 1'b0;
    @(negedge clk);
    ld_Reg = 1'b1;
    repeat (3) @(negedge clk);
    ld_Setup = 1'b1;
    chk("held_setup_once", state, 3'd1);

    // ld_Inst held low 5 cycles on a NOP: one op_done, flags untouched
    pulse(4'b1000, 10'b0000000000);
    pulse(4'b0100, 10'b1001000000);
    chk("nop_armed", state, 3'd3);
    pulses = 0;
    @(negedge clk);
    ld_Inst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (op_done) pulses++;
    end
    ld_Inst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (op_done) pulses++;
    end
    chk("held_inst_pulses", pulses, 1);
    chk("nop_flags", Flags, 5'b00101);
    chk("nop_r0", RdestOut, 16'h0000);

    // Reset pulsed during EXEC
    pulse(4'b1000, 10'b0011000000);
    pulse(4'b0100, 10'b0000100000);
    pulse(4'b0010, 10'b0000000001);
    pulse(4'b0001, 10'd0);
    chk("pre_rst_exec", state, 3'd4);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_state", state, 3'd0);
    chk("mid_rst_flags", Flags, 5'b00000);
    chk("mid_rst_rdest", RdestOut, 16'h0000);
    chk("mid_rst_op_done", op_done, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_op_done", op_done, 1'b0);
    chk("post_rst_state", state, 3'd0);
    pulse(4'b1000, 10'b0011000000);
    chk("post_rst_r3", RdestOut, 16'h0000);

    // CLR after non-zero state
    run_imm("mov_r1", 10'b0001000000, 10'b0101100000, 10'b0101010101);
    chk("mov_r1", RdestOut, 16'h0155);
    run_reg("cmp_r1r1", 10'b0001000100, 10'b0110000000);
    chk("cmp_eq_flags", Flags, 5'b00010);
    run_reg("clr", 10'b0001000100, 10'b1111000000);
`ifdef REGFILE_CLR_ALL_EN
    chk("clr_r1", RdestOut, 16'h0000);
    chk("clr_flags", Flags, 5'b00000);
`else
    chk("clr_r1", RdestOut, 16'h0155);
    chk("clr_flags", Flags, 5'b00010);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
